// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end with instruction queue and branch prediction
//
// Fetches one 32-bit word at a time from the memory controller, predicts the
// next PC for JAL and conditional branches, and buffers {inst, PC, prediction}
// in a circular instruction queue for the decoder. Fetch parks on a JALR until
// the decoder returns the resolved target; a ROB rollback flushes the queue and
// redirects fetch.
//
// Optional feature macro: IFETCH_BHT_EN
//   defined   - 2^BHT_BITS two-bit saturating counters predict branches and
//               are trained by br_upd / br_upd_pc / br_upd_taken
//   undefined - static backward-taken prediction; training inputs ignored
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rdy                           global enable; low freezes all state
//   rollback, rollback_pc         flush and redirect from the ROB
//   mem_req, mem_addr             fetch request (registered, held until mem_done)
//   mem_done, mem_data            returned word, one-cycle pulse
//   inst_rdy, inst, inst_PC,
//   inst_is_Jump                  queue head presented to the decoder
//   dec_done                      decoder consumed the head this cycle
//   jalr_pause_rej, jalr_pc       resolved JALR target
//   br_upd, br_upd_pc,
//   br_upd_taken                  committed branch outcome for BHT training

module ifetch_unit #(
   parameter int          IQ_DEPTH = 16,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          BHT_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic [31:0] rollback_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   output logic        inst_rdy,
   output logic [31:0] inst,
   output logic [31:0] inst_PC,
   output logic        inst_is_Jump,
   input  logic        dec_done,
   input  logic        jalr_pause_rej,
   input  logic [31:0] jalr_pc,
   input  logic        br_upd,
   input  logic [31:0] br_upd_pc,
   input  logic        br_upd_taken
);

   localparam int PW = $clog2(IQ_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_JALR_WAIT} state_t;

   state_t          state, state_nxt;
   logic [31:0]     pc, pc_nxt;
   logic            req_nxt;
   logic [31:0]     addr_nxt;
   logic            enq, deq, taken_pred, enq_pred;

   logic [31:0]     q_inst [IQ_DEPTH];
   logic [31:0]     q_pc   [IQ_DEPTH];
   logic            q_pred [IQ_DEPTH];
   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   count;

   logic [31:0]     imm_j, imm_b;

   assign imm_j = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12], mem_data[20],
                   mem_data[30:21], 1'b0};
   assign imm_b = {{19{mem_data[31]}}, mem_data[31], mem_data[7], mem_data[30:25],
                   mem_data[11:8], 1'b0};

`ifdef IFETCH_BHT_EN
   logic [1:0]          bht [2**BHT_BITS];
   logic [BHT_BITS-1:0] bht_rd_idx, bht_wr_idx;

   assign bht_rd_idx = pc[BHT_BITS+1:2];
   assign bht_wr_idx = br_upd_pc[BHT_BITS+1:2];
   assign taken_pred = bht[bht_rd_idx][1];

   // Training runs regardless of rollback; a same-cycle lookup sees the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**BHT_BITS; i++) bht[i] <= 2'b01;
      end else if (rdy && br_upd) begin
         if (br_upd_taken && bht[bht_wr_idx] != 2'b11)
            bht[bht_wr_idx] <= bht[bht_wr_idx] + 2'b01;
         else if (!br_upd_taken && bht[bht_wr_idx] != 2'b00)
            bht[bht_wr_idx] <= bht[bht_wr_idx] - 2'b01;
      end
   end

   wire unused_bht = &{1'b0, br_upd_pc[31:BHT_BITS+2], br_upd_pc[1:0]};
`else
   // Backward branches (negative offset) predicted taken.
   assign taken_pred = mem_data[31];

   wire unused_bht = &{1'b0, br_upd, br_upd_pc, br_upd_taken};
`endif

   // Head presentation; rollback hides the head in the flush cycle itself.
   assign inst_rdy     = (count != '0) && !rollback;
   assign inst         = (count != '0) ? q_inst[head] : 32'h0;
   assign inst_PC      = (count != '0) ? q_pc[head]   : 32'h0;
   assign inst_is_Jump = (count != '0) ? q_pred[head] : 1'b0;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      req_nxt   = mem_req;
      addr_nxt  = mem_addr;
      enq       = 1'b0;
      enq_pred  = 1'b0;
      deq       = dec_done && inst_rdy;
      if (rollback) begin
         state_nxt = S_IDLE;
         pc_nxt    = rollback_pc;
         req_nxt   = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (count < CW'(IQ_DEPTH)) begin
                  req_nxt   = 1'b1;
                  addr_nxt  = {pc[31:2], 2'b00};
                  state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_done) begin
                  enq     = 1'b1;
                  req_nxt = 1'b0;
                  if (mem_data[6:0] == OP_JALR) begin
                     state_nxt = S_JALR_WAIT;
                  end else begin
                     state_nxt = S_IDLE;
                     pc_nxt    = pc + 32'd4;
                     if (mem_data[6:0] == OP_JAL) begin
                        pc_nxt   = pc + imm_j;
                        enq_pred = 1'b1;
                     end else if (mem_data[6:0] == OP_BRANCH) begin
                        enq_pred = taken_pred;
                        if (taken_pred) pc_nxt = pc + imm_b;
                     end
                  end
               end
            end
            S_JALR_WAIT: begin
               if (jalr_pause_rej) begin
                  pc_nxt    = jalr_pc;
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         mem_req  <= 1'b0;
         mem_addr <= 32'h0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (rdy) begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         mem_req  <= req_nxt;
         mem_addr <= addr_nxt;
         if (rollback) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (enq) begin
               q_inst[tail] <= mem_data;
               q_pc[tail]   <= pc;
               q_pred[tail] <= enq_pred;
               tail         <= tail + 1'b1;
            end
            if (deq) head <= head + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (!enq && deq) count <= count - 1'b1;
         end
      end
   end

endmodule
